// File: rtl/tpu_job_sequencer_if.sv
// Host stream handshakes plus the tpuv1 memory-mapped bus, bundled for the job sequencer.
// The sequencer connects through the master modport because it is the only master of the TPU bus.
// The slave modport is the far side: host command/stream logic together with the tpuv1 instance.
interface tpu_job_sequencer_if #(
    parameter int ADDRW = 16,
    parameter int DATAW = 64
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_acc;
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_dataIn;
    logic [DATAW-1:0] tpu_dataOut;

    modport master (
        input  cmd_valid, cmd_acc, in_valid, in_data, out_ready, tpu_dataOut,
        output cmd_ready, in_ready, out_valid, out_data, out_last, busy, done,
               tpu_r_w, tpu_addr, tpu_dataIn
    );

    modport slave (
        output cmd_valid, cmd_acc, in_valid, in_data, out_ready, tpu_dataOut,
        input  cmd_ready, in_ready, out_valid, out_data, out_last, busy, done,
               tpu_r_w, tpu_addr, tpu_dataIn
    );
endinterface

// File: rtl/tpu_job_sequencer.sv
// Runs one matrix-multiply job on tpuv1 without host help per bus transaction.
// Flow: optional C clear, DIM A-row writes, DIM B-row writes, matmul start, a fixed wait,
// then all C half-rows streamed out. Bus address/data are combinational from the state,
// the index counter and the input beat, so an accepted beat is written in the same cycle.
module tpu_job_sequencer #(
    parameter int DIM       = 8,
    parameter int ADDRW     = 16,
    parameter int DATAW     = 64,
    parameter int MM_CYCLES = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    tpu_job_sequencer_if.master bus
);

    localparam int IDXW  = $clog2(2 * DIM) + 1;
    localparam int WAITW = $clog2(MM_CYCLES + 1);

    localparam logic [ADDRW-1:0] A_BASE  = ADDRW'('h100);
    localparam logic [ADDRW-1:0] B_ADDR  = ADDRW'('h200);
    localparam logic [ADDRW-1:0] C_BASE  = ADDRW'('h300);
    localparam logic [ADDRW-1:0] MM_ADDR = ADDRW'('h400);

    localparam logic [IDXW-1:0]  IDX_ROW_LAST  = IDXW'(DIM - 1);
    localparam logic [IDXW-1:0]  IDX_HALF_LAST = IDXW'(2 * DIM - 1);
    localparam logic [WAITW-1:0] WAIT_LOAD     = WAITW'(MM_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR_C,
        LD_A,
        LD_B,
        MM_GO,
        MM_WAIT,
        RD_C,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [IDXW-1:0]  r_idx;
    logic [IDXW-1:0]  w_idxNext;
    logic [WAITW-1:0] r_wait;
    logic [WAITW-1:0] w_waitNext;
    logic [ADDRW-1:0] w_rowOffset;

    // A rows sit 8 bytes apart and each C row is two 8-byte halves, so both A row idx
    // and C beat idx (row idx>>1, half idx[0]) land at base + 8*idx.
    assign w_rowOffset = ADDRW'(r_idx) << 3;

    // State, index and wait counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_idx   <= w_idxNext;
            r_wait  <= w_waitNext;
        end
    end

    // Next-state logic and every output; all outputs default to the idle bus / no handshake.
    // The accumulate flag is only needed to pick the first state, so it is consumed at
    // acceptance instead of being held in a register.
    always_comb begin
        w_stateNext    = r_state;
        w_idxNext      = r_idx;
        w_waitNext     = r_wait;

        bus.cmd_ready  = 1'b0;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        bus.out_last   = 1'b0;
        bus.busy       = 1'b1;
        bus.done       = 1'b0;
        bus.tpu_r_w    = 1'b0;
        bus.tpu_addr   = '0;
        bus.tpu_dataIn = '0;

        case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    w_idxNext   = '0;
                    w_stateNext = bus.cmd_acc ? LD_A : CLR_C;
                end
            end

            CLR_C: begin
                bus.tpu_r_w  = 1'b1;
                bus.tpu_addr = C_BASE + w_rowOffset;
                if (r_idx == IDX_HALF_LAST) begin
                    w_idxNext   = '0;
                    w_stateNext = LD_A;
                end else begin
                    w_idxNext = r_idx + IDXW'(1);
                end
            end

            LD_A: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.tpu_r_w    = 1'b1;
                    bus.tpu_addr   = A_BASE + w_rowOffset;
                    bus.tpu_dataIn = bus.in_data;
                    if (r_idx == IDX_ROW_LAST) begin
                        w_idxNext   = '0;
                        w_stateNext = LD_B;
                    end else begin
                        w_idxNext = r_idx + IDXW'(1);
                    end
                end
            end

            LD_B: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.tpu_r_w    = 1'b1;
                    bus.tpu_addr   = B_ADDR;
                    bus.tpu_dataIn = bus.in_data;
                    if (r_idx == IDX_ROW_LAST) begin
                        w_idxNext   = '0;
                        w_stateNext = MM_GO;
                    end else begin
                        w_idxNext = r_idx + IDXW'(1);
                    end
                end
            end

            MM_GO: begin
                bus.tpu_r_w = 1'b1;
                bus.tpu_addr = MM_ADDR;
                w_waitNext   = WAIT_LOAD;
                w_stateNext  = MM_WAIT;
            end

            MM_WAIT: begin
                if (r_wait == '0) begin
                    w_idxNext   = '0;
                    w_stateNext = RD_C;
                end else begin
                    w_waitNext = r_wait - WAITW'(1);
                end
            end

            RD_C: begin
                bus.tpu_addr  = C_BASE + w_rowOffset;
                bus.out_valid = 1'b1;
                bus.out_data  = bus.tpu_dataOut;
                bus.out_last  = (r_idx == IDX_HALF_LAST);
                if (bus.out_ready) begin
                    if (r_idx == IDX_HALF_LAST) begin
                        w_stateNext = DONE;
                    end else begin
                        w_idxNext = r_idx + IDXW'(1);
                    end
                end
            end

            DONE: begin
                bus.done    = 1'b1;
                w_stateNext = IDLE;
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // A presented C beat keeps its address until the consumer accepts it.
    a_outHold: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.tpu_addr)));

    // A load cycle without a valid beat must not write the TPU.
    a_noStallWrite: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.in_ready && !bus.in_valid) |-> (!bus.tpu_r_w && bus.tpu_addr == '0));

    // The done pulse is followed by an idle, ready sequencer.
    a_doneThenIdle: assert property (@(posedge clk) disable iff (!rst_n)
        bus.done |=> (!bus.busy && bus.cmd_ready && !bus.done));

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Self-checking bench for tpu_job_sequencer with a small behavioural tpuv1 model.
// Expected C beats are pushed to a scoreboard when a job is issued; a negedge monitor pops
// and compares them on every accepted beat and also polices every bus cycle.
module tb_tpu_job_sequencer;

    localparam int DIM       = 8;
    localparam int ADDRW     = 16;
    localparam int DATAW     = 64;
    localparam int MM_CYCLES = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tpu_job_sequencer_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

    tpu_job_sequencer #(
        .DIM      (DIM),
        .ADDRW    (ADDRW),
        .DATAW    (DATAW),
        .MM_CYCLES(MM_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard
    logic [DATAW-1:0] expData[$];
    logic             expLast[$];

    // bus statistics kept by the monitor
    int aWrites   = 0;
    int bWrites   = 0;
    int cWrites   = 0;
    int mmWrites  = 0;
    int beatsSeen = 0;
    int gapCnt    = 0;
    int lastGap   = -1;
    bit gapActive = 0;
    bit expDone   = 0;
    bit holdValid = 0;
    logic [ADDRW-1:0] holdAddr;
    logic [DATAW-1:0] holdData;

    // tpuv1 model state (not affected by sequencer reset)
    logic [7:0]  aMem[DIM][DIM];
    logic [7:0]  bMem[DIM][DIM];
    logic [15:0] cMem[DIM][DIM];
    int          bPtr = 0;
    logic [15:0] sumTmp;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [DATAW-1:0] rowData(input int beat);
        logic [DATAW-1:0] w;
        w = '0;
        if (beat < DIM) begin
            w[8*beat +: 8] = 8'h01;
        end else begin
            for (int j = 0; j < DIM; j++) w[8*j +: 8] = 8'(beat - DIM + 1);
        end
        return w;
    endfunction

    initial begin
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                aMem[r][c] = '0;
                bMem[r][c] = '0;
                cMem[r][c] = '0;
            end
        end
    end

    // tpuv1 model: A rows by address, B rows shift in order, C halves writable, 0x400 does C += A*B
    always @(posedge clk) begin
        if (bus.tpu_r_w === 1'b1) begin
            if (bus.tpu_addr >= 16'h100 && bus.tpu_addr < 16'h140) begin
                for (int j = 0; j < DIM; j++)
                    aMem[(int'(bus.tpu_addr) - 'h100) / 8][j] <= bus.tpu_dataIn[8*j +: 8];
            end else if (bus.tpu_addr == 16'h200) begin
                for (int j = 0; j < DIM; j++) bMem[bPtr][j] <= bus.tpu_dataIn[8*j +: 8];
                bPtr <= (bPtr + 1) % DIM;
            end else if (bus.tpu_addr >= 16'h300 && bus.tpu_addr < 16'h380) begin
                for (int l = 0; l < 4; l++)
                    cMem[bus.tpu_addr[6:4]][(bus.tpu_addr[3] ? 4 : 0) + l] <= bus.tpu_dataIn[16*l +: 16];
            end else if (bus.tpu_addr == 16'h400) begin
                for (int r = 0; r < DIM; r++) begin
                    for (int j = 0; j < DIM; j++) begin
                        sumTmp = cMem[r][j];
                        for (int k = 0; k < DIM; k++) sumTmp = sumTmp + aMem[r][k] * bMem[k][j];
                        cMem[r][j] <= sumTmp;
                    end
                end
                bPtr <= 0;
            end
        end
    end

    // Combinational C readback, lanes 4h..4h+3 of the addressed row
    always_comb begin
        bus.tpu_dataOut = '0;
        if (bus.tpu_addr >= 16'h300 && bus.tpu_addr < 16'h380) begin
            for (int l = 0; l < 4; l++)
                bus.tpu_dataOut[16*l +: 16] = cMem[bus.tpu_addr[6:4]][(bus.tpu_addr[3] ? 4 : 0) + l];
        end
    end

    // Monitor: scoreboard pops, done timing, backpressure hold, bus legality and matmul wait length
    always @(negedge clk) begin
        if (!rst_n) begin
            gapActive = 0;
            expDone   = 0;
            holdValid = 0;
        end else begin
            if (bus.done || expDone) checkOutput("done pulse", bus.done, expDone);
            expDone = bus.out_valid && bus.out_ready && bus.out_last;

            if (bus.out_valid && bus.out_ready) begin
                if (expData.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected C beat: got %h, expected no beat", bus.out_data);
                end else begin
                    checkOutput("C beat data", bus.out_data, expData.pop_front());
                    checkOutput("C beat last", bus.out_last, expLast.pop_front());
                end
                beatsSeen++;
                holdValid = 0;
            end else if (bus.out_valid) begin
                if (holdValid) begin
                    checkOutput("held C addr", bus.tpu_addr, holdAddr);
                    checkOutput("held C data", bus.out_data, holdData);
                end
                holdValid = 1;
                holdAddr  = bus.tpu_addr;
                holdData  = bus.out_data;
            end

            if (gapActive) begin
                if (bus.out_valid) begin
                    lastGap   = gapCnt;
                    gapActive = 0;
                end else if (!bus.tpu_r_w && bus.tpu_addr == 16'h0) begin
                    gapCnt++;
                end else begin
                    gapCnt += 1000;
                end
            end

            if (bus.tpu_r_w) begin
                if (bus.tpu_addr >= 16'h100 && bus.tpu_addr < 16'h140) begin
                    checkOutput("A write addr", bus.tpu_addr, 16'(16'h100 + 8 * (aWrites % DIM)));
                    checkOutput("A write data", bus.tpu_dataIn, bus.in_data);
                    checkOutput("A write on valid beat", bus.in_valid, 1'b1);
                    aWrites++;
                end else if (bus.tpu_addr == 16'h200) begin
                    checkOutput("B write data", bus.tpu_dataIn, bus.in_data);
                    checkOutput("B write on valid beat", bus.in_valid, 1'b1);
                    bWrites++;
                end else if (bus.tpu_addr >= 16'h300 && bus.tpu_addr < 16'h380) begin
                    checkOutput("C clear addr", bus.tpu_addr, 16'(16'h300 + 8 * (cWrites % (2 * DIM))));
                    checkOutput("C clear data", bus.tpu_dataIn, 64'h0);
                    cWrites++;
                end else if (bus.tpu_addr == 16'h400) begin
                    mmWrites++;
                    gapActive = 1;
                    gapCnt    = 0;
                    lastGap   = -1;
                end else begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL write address: got %h, expected a mapped address", bus.tpu_addr);
                end
            end else if (!bus.out_valid) begin
                checkOutput("idle addr", bus.tpu_addr, 16'h0);
                checkOutput("idle dataIn", bus.tpu_dataIn, 64'h0);
            end

            if (bus.in_ready && !bus.in_valid) checkOutput("no write on stall", bus.tpu_r_w, 1'b0);
        end
    end

    // One full job (or a job aborted by reset during MM_WAIT)
    task automatic applyStimulus(input bit acc, input bit stallIn, input bit backPressure,
                                 input int mult, input bit abortInWait);
        int a0, b0, c0, m0, beats0, cyc, beat, seenValid;
        bit accept;
        logic [DATAW-1:0] d;
        a0 = aWrites; b0 = bWrites; c0 = cWrites; m0 = mmWrites; beats0 = beatsSeen;

        if (!abortInWait) begin
            for (int r = 0; r < DIM; r++) begin
                for (int h = 0; h < 2; h++) begin
                    for (int l = 0; l < 4; l++) d[16*l +: 16] = 16'(mult * (r + 1));
                    expData.push_back(d);
                    expLast.push_back(r == DIM - 1 && h == 1);
                end
            end
        end

        cyc = 0;
        while (!bus.cmd_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checkOutput("cmd_ready before job", bus.cmd_ready, 1'b1);
        bus.out_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_acc   = acc;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_acc   = 1'b0;
        checkOutput("busy after cmd", bus.busy, 1'b1);
        checkOutput("cmd_ready after cmd", bus.cmd_ready, 1'b0);

        beat = 0;
        cyc  = 0;
        while (beat < 2 * DIM && cyc < 400) begin
            bus.in_valid = !(stallIn && (cyc % 2 == 1));
            bus.in_data  = rowData(beat);
            @(negedge clk);
            accept = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (accept) beat++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        checkOutput("load beats accepted", beat, 2 * DIM);

        if (abortInWait) begin
            cyc = 0;
            while (mmWrites == m0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
            checkOutput("matmul issued before abort", mmWrites - m0, 1);
            repeat (10) begin @(posedge clk); #1; end
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            checkOutput("abort cmd_ready", bus.cmd_ready, 1'b1);
            checkOutput("abort busy", bus.busy, 1'b0);
            checkOutput("abort out_valid", bus.out_valid, 1'b0);
            checkOutput("abort addr", bus.tpu_addr, 16'h0);
            seenValid = 0;
            repeat (40) begin @(negedge clk); if (bus.out_valid) seenValid++; end
            checkOutput("no beats after abort", seenValid, 0);
            @(posedge clk); #1;
            return;
        end

        if (backPressure) begin
            cyc = 0;
            while (!bus.out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
            checkOutput("first C beat presented", bus.out_valid, 1'b1);
            repeat (3) begin @(posedge clk); #1; end
            bus.out_ready = 1'b0;
            repeat (5) begin
                @(negedge clk);
                checkOutput("stalled beat addr", bus.tpu_addr, 16'h318);
                checkOutput("stalled beat valid", bus.out_valid, 1'b1);
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
        end

        cyc = 0;
        while (!bus.done && cyc < 300) begin @(negedge clk); cyc++; end
        checkOutput("done seen", bus.done, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("idle busy", bus.busy, 1'b0);
        checkOutput("idle cmd_ready", bus.cmd_ready, 1'b1);
        checkOutput("idle out_valid", bus.out_valid, 1'b0);

        checkOutput("A writes per job", aWrites - a0, DIM);
        checkOutput("B writes per job", bWrites - b0, DIM);
        checkOutput("C clear writes per job", cWrites - c0, acc ? 0 : 2 * DIM);
        checkOutput("matmul writes per job", mmWrites - m0, 1);
        checkOutput("matmul wait cycles", lastGap, MM_CYCLES);
        checkOutput("C beats per job", beatsSeen - beats0, 2 * DIM);
        checkOutput("scoreboard drained", expData.size(), 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_acc   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset cmd_ready", bus.cmd_ready, 1'b1);
        checkOutput("reset busy", bus.busy, 1'b0);
        checkOutput("reset done", bus.done, 1'b0);
        checkOutput("reset in_ready", bus.in_ready, 1'b0);
        checkOutput("reset out_valid", bus.out_valid, 1'b0);
        checkOutput("reset out_last", bus.out_last, 1'b0);
        checkOutput("reset tpu_r_w", bus.tpu_r_w, 1'b0);
        checkOutput("reset tpu_addr", bus.tpu_addr, 16'h0);
        checkOutput("reset tpu_dataIn", bus.tpu_dataIn, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] job 1: identity x B, clear C");
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 1'b0);
        $display("[TB] job 2: same job accumulated");
        applyStimulus(1'b1, 1'b0, 1'b0, 2, 1'b0);
        $display("[TB] job 3: stalled input stream");
        applyStimulus(1'b0, 1'b1, 1'b0, 1, 1'b0);
        $display("[TB] job 4: output backpressure on beat 3");
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 1'b0);
        $display("[TB] job 5: reset during matmul wait");
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 1'b1);
        $display("[TB] job 6: clean job after abort");
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
